// File: rtl/pkt_buf_pkg.sv
// Shared types and constants for the packet buffer: write-side FSM states,
// the RAM word layout and the saturating counter helper.
package pkt_buf_pkg;

    localparam int BYTE_W          = 8;
    localparam int MAX_FRAME_BYTES = 1522;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISCARD
    } wr_state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } buf_word_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read (data appears the cycle after rd_en).
module sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and read register carry no reset so this maps onto block RAM.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/frame_commit_buffer.sv
// Store-and-forward frame buffer: bytes are written speculatively and only
// become readable once the frame's last byte commits without a drop.
module frame_commit_buffer
    import pkt_buf_pkg::*;
#(
    parameter int DATA_W    = BYTE_W,
    parameter int ADDR_W    = 12,
    parameter int MAX_FRAME = MAX_FRAME_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_abort,
    input  logic              drop_req,
    output logic              drop_write,
    output logic              almost_full,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [15:0]       frames_committed,
    output logic [15:0]       frames_dropped
);

    localparam int               PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH   = PTR_ONE << ADDR_W;
    localparam logic [PTR_W-1:0] MARGIN  = PTR_W'(MAX_FRAME);

    wr_state_t        wr_state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] commit_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] used;
    logic             full;
    logic             empty_committed;

    assign used            = wr_ptr - rd_ptr;
    assign full            = (used == DEPTH);
    assign empty_committed = (rd_ptr == commit_ptr);

    logic      drop_now;
    logic      wr_en;
    buf_word_t wr_word;

    assign wr_word = {in_last, in_data};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        drop_now = 1'b0;
        unique case (wr_state)
            IDLE:    drop_now = in_valid & (drop_req | in_abort | full);
            WRITE:   drop_now = drop_req | in_abort | (in_valid & full);
            default: drop_now = 1'b0;
        endcase
        wr_en = in_valid && !drop_now && (wr_state != DISCARD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_state         <= IDLE;
            wr_ptr           <= '0;
            commit_ptr       <= '0;
            drop_write       <= 1'b0;
            frames_committed <= '0;
            frames_dropped   <= '0;
        end else begin
            drop_write <= drop_now;
            if (drop_now) begin
                // Rewinding to the commit point discards the partial frame in one step.
                wr_ptr         <= commit_ptr;
                frames_dropped <= sat_inc(frames_dropped);
                wr_state       <= (in_valid && in_last) ? IDLE : DISCARD;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (in_last) begin
                    commit_ptr       <= wr_ptr + PTR_ONE;
                    frames_committed <= sat_inc(frames_committed);
                    wr_state         <= IDLE;
                end else begin
                    wr_state <= WRITE;
                end
            end else if (wr_state == DISCARD && in_valid && in_last) begin
                wr_state <= IDLE;
            end
        end
    end

    logic      rd_en;
    logic      ram_vld;
    logic      skid_vld;
    logic      pop;
    logic [1:0] in_flight;
    buf_word_t rd_word;
    buf_word_t skid_word;

    sdp_ram #(
        .WIDTH  ($bits(buf_word_t)),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    // Bytes held in the output pair plus one in the RAM read register never exceed two.
    assign pop       = out_valid & out_ready;
    assign in_flight = 2'(out_valid) + 2'(skid_vld) + 2'(ram_vld);
    assign rd_en     = !empty_committed && ((in_flight < 2'd2) || (in_flight == 2'd2 && pop));

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr      <= '0;
            ram_vld     <= 1'b0;
            skid_vld    <= 1'b0;
            skid_word   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            ram_vld     <= rd_en;
            almost_full <= (DEPTH - used) < MARGIN;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (!out_valid || pop) begin
                if (skid_vld) begin
                    {out_last, out_data} <= skid_word;
                    out_valid            <= 1'b1;
                    skid_vld             <= ram_vld;
                    skid_word            <= rd_word;
                end else if (ram_vld) begin
                    {out_last, out_data} <= rd_word;
                    out_valid            <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (ram_vld) begin
                skid_vld  <= 1'b1;
                skid_word <= rd_word;
            end
        end
    end

endmodule
